vector_sweep: RTL and testbench
===============================

VECTOR_SWEEP -- requirements
Module: vector_sweep

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 3, giving the cycles each input vector is held; legal range 1..255.
REQ-002 SHALL have parameter EXPECT, default 8'h5F, giving the golden truth table; bit i is the expected y for {a,b,c} = i.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: the reset; synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: sweep request, sampled only in IDLE.
REQ-006 SHALL have ports a, b, c, each output, 1 bit: registered stimulus to the downstream combinational circuit.
REQ-007 SHALL have port y, input, 1 bit: response of the combinational circuit; the block treats it as combinational from a, b, c.
REQ-008 SHALL have port busy, output, 1 bit: high while state is DRIVE.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse marking sweep completion.
REQ-010 SHALL have port table, output, 8 bits: captured y, with bit i for vector i.
REQ-011 SHALL have port mismatch, output, 8 bits: table XOR EXPECT, registered.
REQ-012 SHALL have port pass, output, 1 bit: high when mismatch is 8'h00 after a completed sweep.

Function
REQ-013 SHALL implement a state machine with states IDLE, DRIVE and DONE.
REQ-014 SHALL, in IDLE with start=1, clear table, move to DRIVE, and set the vector index idx=0 and the hold counter hcnt=0.
REQ-015 SHALL drive {a,b,c}=idx throughout DRIVE, a being the MSB, and drive {a,b,c}=3'b000 in IDLE and DONE.
REQ-016 SHALL hold each vector for exactly HOLD_CYCLES cycles, with hcnt counting 0..HOLD_CYCLES-1.
REQ-017 SHALL, on the edge where hcnt=HOLD_CYCLES-1, write y into table[idx], reset hcnt to 0, and increment idx.
REQ-018 SHALL, when that edge occurs with idx=7, move to DONE instead of incrementing; idx SHALL never wrap within a sweep.
REQ-019 SHALL, in DONE, load mismatch with table XOR EXPECT (the bit-7 capture included via bypass), set pass=(mismatch value==0), assert done for exactly that one cycle, and return to IDLE.
REQ-020 SHALL give latency as follows, measured from the start-accept edge: DRIVE lasts 8*HOLD_CYCLES cycles, and done is high in cycle 8*HOLD_CYCLES+1.
REQ-021 SHALL ignore start while in DRIVE or DONE, with no queuing.
REQ-022 SHALL accept start held continuously, giving back-to-back sweeps with period 8*HOLD_CYCLES+2 cycles.
REQ-023 SHALL hold table, mismatch and pass stable from DONE until the next accepted start.
REQ-024 SHALL, on the next accepted start, clear table to 0 and leave mismatch and pass unchanged until the following DONE.

Reset
REQ-025 SHALL, when rst=1 at an edge, force state=IDLE, idx=0, hcnt=0, a=b=c=0, busy=0, done=0, table=8'h00, mismatch=8'h00 and pass=0.
REQ-026 SHALL give rst priority over start and over every state transition.
REQ-027 SHALL, on rst mid-sweep, abort the sweep with no done pulse, and SHALL discard any partial table.

Verification
REQ-028 SHALL cover a golden run: rst, then a start pulse with y = !(a&c) modelled -> {a,b,c} steps 000..111 with each vector held 3 cycles, done in cycle 25 after accept, table=8'h5F, mismatch=8'h00, pass=1.
REQ-029 SHALL cover a stuck-at fault: y tied to 1 -> table=8'hFF, mismatch=8'hA0, pass=0.
REQ-030 SHALL cover continuous start: start held high for 60 cycles -> done pulses 26 cycles apart, with busy low for exactly 2 cycles between sweeps.
REQ-031 SHALL cover abort: rst asserted while idx=4 -> next cycle all outputs are 0 and no done occurs; a subsequent start gives a full golden result.
REQ-032 SHALL cover start while busy: start pulsed at idx=2 -> no effect on sequence or timing.
REQ-033 SHALL cover minimum hold: HOLD_CYCLES=1 -> one vector per cycle, done in cycle 9, golden table=8'h5F.

Source files
------------

// File: rtl/vector_sweep.sv
// vector_sweep
//   Sweeps a 3-input combinational circuit through all eight input vectors,
//   holding each one for HOLD_CYCLES cycles, captures the response y for each
//   vector into an 8-bit truth table, and compares it to a golden table.
//
// Parameters
//   HOLD_CYCLES : cycles each vector is held (1..255)
//   EXPECT      : golden truth table, bit i = expected y for {a,b,c} = i
//
// Ports
//   clk       : clock, all state changes on the rising edge
//   rst       : synchronous active-high reset
//   start     : sweep request, only looked at in IDLE
//   a, b, c   : registered stimulus, a is the MSB of the vector index
//   y         : response of the circuit under test (combinational from a,b,c)
//   busy      : high while vectors are being driven
//   done      : one-cycle pulse; table/mismatch/pass are valid in that cycle
//   vec_table : captured y, bit i for vector i ("table" is a reserved word)
//   mismatch  : vec_table XOR EXPECT, updated once per completed sweep
//   pass      : high when the last completed sweep had no mismatch
module vector_sweep #(
    parameter int          HOLD_CYCLES = 3,
    parameter logic [7:0]  EXPECT      = 8'h5F
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       c,
    input  logic       y,
    output logic       busy,
    output logic       done,
    output logic [7:0] vec_table,
    output logic [7:0] mismatch,
    output logic       pass
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  hcnt_q, hcnt_d;
    logic [2:0]  abc_q, abc_d;
    logic [7:0]  tbl_q, tbl_d;
    logic [7:0]  mm_q, mm_d;
    logic        pass_q, pass_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            hcnt_q  <= 8'd0;
            abc_q   <= 3'd0;
            tbl_q   <= 8'h00;
            mm_q    <= 8'h00;
            pass_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hcnt_q  <= hcnt_d;
            abc_q   <= abc_d;
            tbl_q   <= tbl_d;
            mm_q    <= mm_d;
            pass_q  <= pass_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hcnt_d  = hcnt_q;
        abc_d   = abc_q;
        tbl_d   = tbl_q;
        mm_d    = mm_q;
        pass_d  = pass_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                abc_d = 3'd0;
                if (start) begin
                    // mismatch/pass keep the previous sweep's verdict
                    tbl_d   = 8'h00;
                    idx_d   = 3'd0;
                    hcnt_d  = 8'd0;
                    abc_d   = 3'd0;
                    state_d = DRIVE;
                end
            end

            DRIVE: begin
                if (hcnt_q == HOLD_LAST) begin
                    tbl_d[idx_q] = y;
                    hcnt_d       = 8'd0;
                    if (idx_q == 3'd7) begin
                        // tbl_d already holds the bit-7 capture, so the
                        // verdict is ready in the same cycle as done
                        mm_d    = tbl_d ^ EXPECT;
                        pass_d  = (mm_d == 8'h00);
                        done_d  = 1'b1;
                        abc_d   = 3'd0;
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                        abc_d = idx_q + 3'd1;
                    end
                end else begin
                    hcnt_d = hcnt_q + 8'd1;
                end
            end

            DONE: begin
                abc_d   = 3'd0;
                state_d = IDLE;
            end

            default: begin
                abc_d   = 3'd0;
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == DRIVE);
    end

    assign {a, b, c} = abc_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign vec_table = tbl_q;
    assign mismatch  = mm_q;
    assign pass      = pass_q;

endmodule

// File: tb/tb_vector_sweep.sv
module tb_vector_sweep;

  logic       clk = 1'b0;
  logic       rst, start, start2, fault;
  logic       a, b, c, y, busy, done, pass;
  logic [7:0] vec_table, mismatch;
  logic       a2, b2, c2, y2, busy2, done2, pass2;
  logic [7:0] vec_table2, mismatch2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // circuit under test: y = !(a & c), optionally stuck-at-1
  assign y  = fault ? 1'b1 : !(a & c);
  assign y2 = !(a2 & c2);

  vector_sweep #(.HOLD_CYCLES(3), .EXPECT(8'h5F)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c(c), .y(y),
    .busy(busy), .done(done), .vec_table(vec_table), .mismatch(mismatch), .pass(pass)
  );

  vector_sweep #(.HOLD_CYCLES(1), .EXPECT(8'h5F)) dut1 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .c(c2), .y(y2),
    .busy(busy2), .done(done2), .vec_table(vec_table2), .mismatch(mismatch2), .pass(pass2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one HOLD_CYCLES=3 sweep on dut, optionally pulsing start during
  // cycle 'poke'. Records the observed sequence against the expected one.
  task automatic drive_sweep(input int poke, output int done_cyc, output int seq_errs,
                             output logic [7:0] tbl, output logic [7:0] mm, output logic ps,
                             output logic [7:0] c1_tbl, output logic [7:0] c1_mm, output logic c1_ps);
    logic [2:0] exp_abc;
    logic       exp_busy, exp_done;
    done_cyc = -1; seq_errs = 0;
    tbl = 8'hxx; mm = 8'hxx; ps = 1'bx;
    c1_tbl = vec_table; c1_mm = mismatch; c1_ps = pass;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc <= 26; cyc++) begin
      if (cyc > 1) begin tick(); start = 1'b0; end
      if (cyc == 1) begin c1_tbl = vec_table; c1_mm = mismatch; c1_ps = pass; end
      if (cyc <= 24) begin
        exp_abc = 3'((cyc - 1) / 3); exp_busy = 1'b1; exp_done = 1'b0;
      end else begin
        exp_abc = 3'd0; exp_busy = 1'b0; exp_done = (cyc == 25);
      end
      if ({a, b, c} !== exp_abc || busy !== exp_busy || done !== exp_done) seq_errs++;
      if (done === 1'b1 && done_cyc < 0) begin
        done_cyc = cyc; tbl = vec_table; mm = mismatch; ps = pass;
      end
      if (cyc == poke) start = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; start2 = 1'b1;
    tick(); tick();
    checks++; if (busy !== 1'b0 || busy2 !== 1'b0) begin failures++; $display("FAIL reset_busy got %b/%b exp 0/0", busy, busy2); end
    start = 1'b0; start2 = 1'b0;
    tick();
    checks++; if ({a, b, c, done, pass} !== 5'b0) begin failures++; $display("FAIL reset_bits got abc=%b%b%b done=%b pass=%b exp all 0", a, b, c, done, pass); end
    checks++; if (vec_table !== 8'h00 || mismatch !== 8'h00) begin failures++; $display("FAIL reset_regs got table=%h mm=%h exp 00/00", vec_table, mismatch); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_golden();
    int dc, errs; logic [7:0] t, m, t1, m1; logic p, p1;
    fault = 1'b0;
    drive_sweep(0, dc, errs, t, m, p, t1, m1, p1);
    checks++; if (dc !== 25) begin failures++; $display("FAIL golden_done_cycle got %0d exp 25", dc); end
    checks++; if (errs !== 0) begin failures++; $display("FAIL golden_sequence got %0d errors exp 0", errs); end
    checks++; if (t !== 8'h5F || m !== 8'h00 || p !== 1'b1) begin failures++; $display("FAIL golden_result got table=%h mm=%h pass=%b exp 5f/00/1", t, m, p); end
    tick(); tick(); tick();
    checks++; if (vec_table !== 8'h5F || mismatch !== 8'h00 || pass !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL golden_hold got table=%h mm=%h pass=%b busy=%b exp 5f/00/1/0", vec_table, mismatch, pass, busy); end
  endtask

  task automatic test_stuck();
    int dc, errs; logic [7:0] t, m, t1, m1; logic p, p1;
    fault = 1'b1;
    drive_sweep(0, dc, errs, t, m, p, t1, m1, p1);
    checks++; if (t1 !== 8'h00 || m1 !== 8'h00 || p1 !== 1'b1) begin
      failures++; $display("FAIL stuck_cycle1 got table=%h mm=%h pass=%b exp 00/00/1", t1, m1, p1); end
    checks++; if (dc !== 25 || errs !== 0) begin failures++; $display("FAIL stuck_timing got done=%0d errs=%0d exp 25/0", dc, errs); end
    checks++; if (t !== 8'hFF || m !== 8'hA0 || p !== 1'b0) begin failures++; $display("FAIL stuck_result got table=%h mm=%h pass=%b exp ff/a0/0", t, m, p); end
    fault = 1'b0;
    tick();
  endtask

  task automatic test_continuous();
    int d1 = -1, d2 = -1, ndone = 0, nlow = 0;
    start = 1'b1;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      tick();
      if (done === 1'b1) begin ndone++; if (d1 < 0) d1 = cyc; else if (d2 < 0) d2 = cyc; end
      if (busy !== 1'b1) nlow++;
    end
    start = 1'b0;
    checks++; if (d1 !== 25 || d2 !== 51 || ndone !== 2) begin
      failures++; $display("FAIL cont_done got first=%0d second=%0d count=%0d exp 25/51/2", d1, d2, ndone); end
    checks++; if (nlow !== 4) begin failures++; $display("FAIL cont_busy_low got %0d cycles exp 4", nlow); end
    rst = 1'b1; tick(); rst = 1'b0; tick();
  endtask

  task automatic test_abort();
    int seen = 0, dc, errs; logic [7:0] t, m, t1, m1; logic p, p1;
    start = 1'b1; tick(); start = 1'b0;
    for (int cyc = 2; cyc <= 13; cyc++) tick();
    checks++; if ({a, b, c} !== 3'd4) begin failures++; $display("FAIL abort_idx got %b exp 100", {a, b, c}); end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if ({a, b, c, busy, done, pass} !== 6'b0 || vec_table !== 8'h00 || mismatch !== 8'h00) begin
      failures++; $display("FAIL abort_outputs got abc=%b%b%b busy=%b done=%b pass=%b table=%h mm=%h exp 0", a, b, c, busy, done, pass, vec_table, mismatch); end
    for (int i = 0; i < 30; i++) begin tick(); if (done === 1'b1 || busy === 1'b1) seen++; end
    checks++; if (seen !== 0) begin failures++; $display("FAIL abort_no_done got %0d active cycles exp 0", seen); end
    drive_sweep(0, dc, errs, t, m, p, t1, m1, p1);
    checks++; if (dc !== 25 || errs !== 0 || t !== 8'h5F || m !== 8'h00 || p !== 1'b1) begin
      failures++; $display("FAIL abort_rerun got done=%0d errs=%0d table=%h mm=%h pass=%b exp 25/0/5f/00/1", dc, errs, t, m, p); end
    tick();
  endtask

  task automatic test_start_busy();
    int dc, errs; logic [7:0] t, m, t1, m1; logic p, p1;
    drive_sweep(7, dc, errs, t, m, p, t1, m1, p1);
    checks++; if (dc !== 25 || errs !== 0) begin failures++; $display("FAIL busy_start_timing got done=%0d errs=%0d exp 25/0", dc, errs); end
    checks++; if (t !== 8'h5F || p !== 1'b1) begin failures++; $display("FAIL busy_start_result got table=%h pass=%b exp 5f/1", t, p); end
    tick(); tick(); tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_start_queued got busy=%b exp 0", busy); end
  endtask

  task automatic test_min_hold();
    int dc = -1, errs = 0;
    logic [7:0] t = 8'hxx; logic p = 1'bx;
    start2 = 1'b1; tick(); start2 = 1'b0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      if (cyc > 1) tick();
      if (cyc <= 8) begin
        if ({a2, b2, c2} !== 3'(cyc - 1) || busy2 !== 1'b1) errs++;
      end else if (busy2 !== 1'b0) errs++;
      if (done2 === 1'b1 && dc < 0) begin dc = cyc; t = vec_table2; p = pass2; end
    end
    checks++; if (dc !== 9) begin failures++; $display("FAIL min_hold_done got %0d exp 9", dc); end
    checks++; if (errs !== 0) begin failures++; $display("FAIL min_hold_sequence got %0d errors exp 0", errs); end
    checks++; if (t !== 8'h5F || p !== 1'b1 || mismatch2 !== 8'h00) begin
      failures++; $display("FAIL min_hold_result got table=%h pass=%b mm=%h exp 5f/1/00", t, p, mismatch2); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start2 = 1'b0; fault = 1'b0;
    test_reset();
    test_golden();
    test_stuck();
    test_continuous();
    test_abort();
    test_start_busy();
    test_min_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
